// File: rtl/df_perf_pkg.sv
// Shared types, register map offsets and the saturating-increment helper for
// the dataflow performance monitor.
package df_perf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } run_state_e;

  typedef enum logic [1:0] {
    P_IDLE = 2'd0,
    P_BUSY = 2'd1,
    P_WAIT = 2'd2
  } proc_state_e;

  // Per-channel register offsets within a 4-word window
  localparam logic [1:0] OFF_OCC  = 2'd0;
  localparam logic [1:0] OFF_MAX  = 2'd1;
  localparam logic [1:0] OFF_WBLK = 2'd2;
  localparam logic [1:0] OFF_RBLK = 2'd3;

  // Per-process register offsets within a 4-word window
  localparam logic [1:0] OFF_BUSY  = 2'd0;
  localparam logic [1:0] OFF_STALL = 2'd1;
  localparam logic [1:0] OFF_ITER  = 2'd2;
  localparam logic [1:0] OFF_STAT  = 2'd3;

  // Increment that sticks at the all-ones value of a width-bit counter.
  function automatic logic [63:0] sat_inc(input logic [63:0] value, input int width);
    logic [63:0] max_val;
    max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (value >= max_val) ? value : value + 64'd1;
  endfunction

endpackage

// File: rtl/df_chan_counter.sv
// One monitored FIFO channel: shadow occupancy, peak occupancy, producer and
// consumer block-cycle counters and a sticky under/overflow flag.
module df_chan_counter
  import df_perf_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int DEPTH_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear_i,
  input  logic               count_en_i,
  input  logic               wr_en_i,
  input  logic               rd_en_i,
  input  logic               wr_block_i,
  input  logic               rd_block_i,
  output logic [DEPTH_W-1:0] occ_o,
  output logic [DEPTH_W-1:0] max_occ_o,
  output logic [CNT_W-1:0]   wr_block_cnt_o,
  output logic [CNT_W-1:0]   rd_block_cnt_o,
  output logic               occ_err_o
);

  localparam logic [DEPTH_W-1:0] OCC_FULL = '1;

  logic [DEPTH_W-1:0] occ_q, occ_d;
  logic [DEPTH_W-1:0] max_q, max_d;
  logic [CNT_W-1:0]   wblk_q, wblk_d;
  logic [CNT_W-1:0]   rblk_q, rblk_d;
  logic               err_q, err_d;

  always_comb begin
    // NOTE: every next-state value gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    occ_d  = occ_q;
    max_d  = max_q;
    wblk_d = wblk_q;
    rblk_d = rblk_q;
    err_d  = err_q;
    if (clear_i) begin
      occ_d  = '0;
      max_d  = '0;
      wblk_d = '0;
      rblk_d = '0;
      err_d  = 1'b0;
    end else if (count_en_i) begin
      case ({wr_en_i, rd_en_i})
        2'b10:   if (occ_q == OCC_FULL) err_d = 1'b1;
                 else                   occ_d = occ_q + DEPTH_W'(1);
        2'b01:   if (occ_q == '0)       err_d = 1'b1;
                 else                   occ_d = occ_q - DEPTH_W'(1);
        default: ;
      endcase
      // Peak tracks the post-update occupancy so a new maximum is seen at once
      if (occ_d > max_q) max_d = occ_d;
      if (wr_block_i) wblk_d = CNT_W'(sat_inc(64'(wblk_q), CNT_W));
      if (rd_block_i) rblk_d = CNT_W'(sat_inc(64'(rblk_q), CNT_W));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before this edge, independent of statement order.
    if (!rst_n) begin
      occ_q  <= '0;
      max_q  <= '0;
      wblk_q <= '0;
      rblk_q <= '0;
      err_q  <= 1'b0;
    end else begin
      occ_q  <= occ_d;
      max_q  <= max_d;
      wblk_q <= wblk_d;
      rblk_q <= rblk_d;
      err_q  <= err_d;
    end
  end

  assign occ_o          = occ_q;
  assign max_occ_o      = max_q;
  assign wr_block_cnt_o = wblk_q;
  assign rd_block_cnt_o = rblk_q;
  assign occ_err_o      = err_q;

endmodule

// File: rtl/df_perf_monitor.sv
// On-chip dataflow performance monitor: channel and process counters, hardware
// deadlock detection and a single-cycle-latency register read port.
module df_perf_monitor
  import df_perf_pkg::*;
#(
  parameter int NUM_CHAN  = 3,
  parameter int NUM_PROC  = 3,
  parameter int CNT_W     = 32,
  parameter int DEPTH_W   = 8,
  parameter int DL_THRESH = 1024,
  parameter int ADDR_W    = $clog2(4*(NUM_CHAN+NUM_PROC))
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic                finish_i,
  input  logic [NUM_CHAN-1:0] chan_wr_en_i,
  input  logic [NUM_CHAN-1:0] chan_rd_en_i,
  input  logic [NUM_CHAN-1:0] chan_wr_block_i,
  input  logic [NUM_CHAN-1:0] chan_rd_block_i,
  input  logic [NUM_PROC-1:0] proc_start_i,
  input  logic [NUM_PROC-1:0] proc_done_i,
  input  logic [NUM_PROC-1:0] proc_continue_i,
  input  logic [NUM_PROC-1:0] proc_in_stall_i,
  input  logic [NUM_PROC-1:0] proc_out_stall_i,
  input  logic                rd_req_i,
  input  logic [ADDR_W-1:0]   rd_addr_i,
  output logic                rd_valid_o,
  output logic [CNT_W-1:0]    rd_data_o,
  output logic                running_o,
  output logic                deadlock_o,
  output logic [NUM_CHAN-1:0] occ_err_o
);

  localparam int             DL_W   = $clog2(DL_THRESH + 1);
  localparam logic [DL_W-1:0] DL_MAX = DL_W'(DL_THRESH);
  localparam int             SEL_W  = ADDR_W - 2;

  run_state_e state_q;
  logic       running_q;
  logic       count_en;

  // Top FSM: start always wins and restarts the run from any state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      running_q <= 1'b0;
    end else if (start_i) begin
      state_q   <= RUN;
      running_q <= 1'b1;
    end else if (state_q == RUN && (finish_i || deadlock_o)) begin
      state_q   <= DONE;
      running_q <= 1'b0;
    end
  end

  assign count_en  = (state_q == RUN);
  assign running_o = running_q;

  logic [DEPTH_W-1:0] chan_occ  [NUM_CHAN];
  logic [DEPTH_W-1:0] chan_max  [NUM_CHAN];
  logic [CNT_W-1:0]   chan_wblk [NUM_CHAN];
  logic [CNT_W-1:0]   chan_rblk [NUM_CHAN];
  logic [NUM_CHAN-1:0] chan_err;

  for (genvar i = 0; i < NUM_CHAN; i++) begin : g_chan
    df_chan_counter #(
      .CNT_W  (CNT_W),
      .DEPTH_W(DEPTH_W)
    ) u_chan (
      .clk           (clk),
      .rst_n         (rst_n),
      .clear_i       (start_i),
      .count_en_i    (count_en),
      .wr_en_i       (chan_wr_en_i[i]),
      .rd_en_i       (chan_rd_en_i[i]),
      .wr_block_i    (chan_wr_block_i[i]),
      .rd_block_i    (chan_rd_block_i[i]),
      .occ_o         (chan_occ[i]),
      .max_occ_o     (chan_max[i]),
      .wr_block_cnt_o(chan_wblk[i]),
      .rd_block_cnt_o(chan_rblk[i]),
      .occ_err_o     (chan_err[i])
    );
  end

  assign occ_err_o = chan_err;

  proc_state_e       pstate_q [NUM_PROC];
  proc_state_e       pstate_d [NUM_PROC];
  logic [CNT_W-1:0]  busy_q   [NUM_PROC];
  logic [CNT_W-1:0]  busy_d   [NUM_PROC];
  logic [CNT_W-1:0]  stall_q  [NUM_PROC];
  logic [CNT_W-1:0]  stall_d  [NUM_PROC];
  logic [CNT_W-1:0]  iter_q   [NUM_PROC];
  logic [CNT_W-1:0]  iter_d   [NUM_PROC];
  logic [NUM_PROC-1:0] proc_stall;

  assign proc_stall = proc_in_stall_i | proc_out_stall_i;

  always_comb begin
    pstate_d = pstate_q;
    busy_d   = busy_q;
    stall_d  = stall_q;
    iter_d   = iter_q;
    for (int j = 0; j < NUM_PROC; j++) begin
      if (start_i) begin
        pstate_d[j] = P_IDLE;
        busy_d[j]   = '0;
        stall_d[j]  = '0;
        iter_d[j]   = '0;
      end else if (count_en) begin
        if (pstate_q[j] == P_BUSY) begin
          busy_d[j] = CNT_W'(sat_inc(64'(busy_q[j]), CNT_W));
          if (proc_stall[j]) stall_d[j] = CNT_W'(sat_inc(64'(stall_q[j]), CNT_W));
        end
        // An iteration retires on the done/continue handshake, whether it
        // happens in BUSY or after waiting for continue
        if (pstate_q[j] != P_IDLE && proc_done_i[j] && proc_continue_i[j])
          iter_d[j] = CNT_W'(sat_inc(64'(iter_q[j]), CNT_W));
        case (pstate_q[j])
          P_IDLE: if (proc_start_i[j]) pstate_d[j] = P_BUSY;
          P_BUSY: if (proc_done_i[j]) begin
                    if (!proc_continue_i[j])  pstate_d[j] = P_WAIT;
                    else if (!proc_start_i[j]) pstate_d[j] = P_IDLE;
                  end
          P_WAIT: if (proc_continue_i[j]) pstate_d[j] = P_IDLE;
          default: pstate_d[j] = P_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: these arrays are plain flops, not RAM, so resetting every entry
      // is cheap and required for a clean post-reset read-back.
      for (int j = 0; j < NUM_PROC; j++) begin
        pstate_q[j] <= P_IDLE;
        busy_q[j]   <= '0;
        stall_q[j]  <= '0;
        iter_q[j]   <= '0;
      end
    end else begin
      pstate_q <= pstate_d;
      busy_q   <= busy_d;
      stall_q  <= stall_d;
      iter_q   <= iter_d;
    end
  end

  logic            any_busy;
  logic            busy_unstalled;
  logic            all_stalled;
  logic [DL_W-1:0] dl_cnt_q, dl_cnt_d;
  logic            deadlock_q;

  always_comb begin
    any_busy       = 1'b0;
    busy_unstalled = 1'b0;
    for (int j = 0; j < NUM_PROC; j++) begin
      if (pstate_q[j] == P_BUSY) begin
        any_busy = 1'b1;
        if (!proc_stall[j]) busy_unstalled = 1'b1;
      end
    end
    all_stalled = any_busy & ~busy_unstalled;
    if (!all_stalled)            dl_cnt_d = '0;
    else if (dl_cnt_q == DL_MAX) dl_cnt_d = dl_cnt_q;
    else                         dl_cnt_d = dl_cnt_q + DL_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_cnt_q   <= '0;
      deadlock_q <= 1'b0;
    end else if (start_i) begin
      dl_cnt_q   <= '0;
      deadlock_q <= 1'b0;
    end else if (count_en) begin
      dl_cnt_q <= dl_cnt_d;
      if (dl_cnt_d == DL_MAX) deadlock_q <= 1'b1;
    end
  end

  assign deadlock_o = deadlock_q;

  logic [CNT_W-1:0] rd_word;
  logic             rd_valid_q;
  logic [CNT_W-1:0] rd_data_q;

  // Register map: channel windows first, then process windows; anything
  // beyond the last window decodes to zero.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_CHAN; i++) begin
      if (rd_addr_i[ADDR_W-1:2] == SEL_W'(i)) begin
        case (rd_addr_i[1:0])
          OFF_OCC:  rd_word = CNT_W'(chan_occ[i]);
          OFF_MAX:  rd_word = CNT_W'(chan_max[i]);
          OFF_WBLK: rd_word = chan_wblk[i];
          OFF_RBLK: rd_word = chan_rblk[i];
          default:  rd_word = '0;
        endcase
      end
    end
    for (int j = 0; j < NUM_PROC; j++) begin
      if (rd_addr_i[ADDR_W-1:2] == SEL_W'(NUM_CHAN + j)) begin
        case (rd_addr_i[1:0])
          OFF_BUSY:  rd_word = busy_q[j];
          OFF_STALL: rd_word = stall_q[j];
          OFF_ITER:  rd_word = iter_q[j];
          OFF_STAT:  rd_word = CNT_W'({deadlock_q, |chan_err, pstate_q[j]});
          default:   rd_word = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_req_i;
      if (rd_req_i) rd_data_q <= rd_word;
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;

endmodule

// File: doc/df_perf_monitor.md
Name: df_perf_monitor

Overview:
- Synthesizable, parametrised successor to the testbench dataflow monitor.
- Watches NUM_CHAN dataflow FIFO channels and NUM_PROC dataflow processes of an HLS top, and keeps on-chip performance counters: occupancy, peak depth, full/empty stall cycles, busy/stall cycles and iterations.
- Detects dataflow deadlock in hardware.
- Counters are read through a single-cycle-latency register read port, so profiling works on the board and not only in co-simulation.

Parameters:
- NUM_CHAN, 3, number of monitored FIFO channels.
- NUM_PROC, 3, number of monitored dataflow processes.
- CNT_W, 32, width of every counter and of rd_data.
- DEPTH_W, 8, occupancy counter width (channel depth ≤ 2^DEPTH_W-1).
- DL_THRESH, 1024, consecutive all-stalled cycles that declare deadlock.
- ADDR_W, $clog2(4*(NUM_CHAN+NUM_PROC)), read address width.

Ports:
- clock, in, 1, single clock.
- reset, in, 1, asynchronous active-low reset.
- start, in, 1, pulse: clear all counters and enter RUN.
- finish, in, 1, top-level done: freeze counters (enter DONE).
- chan_wr_en, in, NUM_CHAN, FIFO write accepted (if_write).
- chan_rd_en, in, NUM_CHAN, FIFO read accepted (if_read).
- chan_wr_block, in, NUM_CHAN, producer blocked (~blk_n).
- chan_rd_block, in, NUM_CHAN, consumer blocked (~blk_n).
- proc_start, in, NUM_PROC, process ap_start.
- proc_done, in, NUM_PROC, process ap_done.
- proc_continue, in, NUM_PROC, process ap_continue.
- proc_in_stall, in, NUM_PROC, OR of input blk_n stalls.
- proc_out_stall, in, NUM_PROC, OR of output blk_n stalls.
- rd_req, in, 1, read strobe.
- rd_addr, in, ADDR_W, counter select.
- rd_valid, out, 1, read data valid.
- rd_data, out, CNT_W, counter value.
- running, out, 1, state==RUN.
- deadlock, out, 1, sticky deadlock flag.
- occ_err, out, NUM_CHAN, sticky per-channel underflow/overflow flags.

Behaviour:
- Reset (reset=0, async):
  - State IDLE; all counters 0.
  - rd_valid=0, rd_data=0, running=0, deadlock=0, occ_err=0.
- Top FSM:
  - IDLE→RUN on start. The start cycle clears all counters, deadlock and occ_err; counting begins the next cycle.
  - RUN→DONE on finish, or when deadlock asserts.
  - DONE→RUN on start, with the same clear.
  - start during RUN clears and restarts the run.
  - start and finish in the same cycle: start wins.
- Counting happens only in RUN. In IDLE and DONE all counters hold.
- Every CNT_W counter saturates at all-ones and never wraps.
- Channel occupancy (per channel):
  - wr_en&~rd_en: +1. rd_en&~wr_en: -1. Both or neither: hold.
  - -1 at 0: hold 0, set occ_err[i]. +1 at 2^DEPTH_W-1: hold, set occ_err[i].
  - max_occ updates to the new occupancy whenever it exceeds max_occ. It compares against the next-state value, so the peak is seen in the same cycle.
  - wr_block_cnt increments on cycles with chan_wr_block=1; rd_block_cnt increments on cycles with chan_rd_block=1.
- Process tracker (per process):
  - States P_IDLE, P_BUSY, P_WAIT.
  - P_IDLE→P_BUSY on start.
  - P_BUSY→P_WAIT on done&~continue.
  - P_BUSY→P_IDLE on done&continue&~start; stays P_BUSY on done&continue&start (back-to-back iteration).
  - P_WAIT→P_IDLE on continue.
  - iter_cnt increments on done&continue.
  - busy_cnt increments every cycle in P_BUSY.
  - stall_cnt increments in P_BUSY when in_stall|out_stall.
- Deadlock:
  - all_stalled = (≥1 process in P_BUSY) and every P_BUSY process has in_stall|out_stall.
  - A DL counter increments while all_stalled and resets to 0 otherwise.
  - When it reaches DL_THRESH, deadlock=1 (sticky) and the FSM moves to DONE in the next cycle.
- Read port:
  - rd_req in cycle N → rd_valid=1 and rd_data in cycle N+1. rd_valid is a one-cycle pulse per request, back-to-back capable.
  - Reads are legal in any state and never disturb counters.
  - Channel i (base 4i): +0 occupancy, +1 max_occ, +2 wr_block_cnt, +3 rd_block_cnt. Occupancy fields are zero-extended.
  - Process j (base 4*NUM_CHAN+4j): +0 busy_cnt, +1 stall_cnt, +2 iter_cnt, +3 status = {deadlock, occ_err[i]-OR, proc state[1:0]} in the LSBs.
  - Out-of-range address returns 0 with rd_valid=1.
- Reset mid-run: immediate return to the reset values above; no partial data is retained.

Decomposition:
- Package df_perf_pkg holds:
  - run_state_e (IDLE/RUN/DONE) and proc_state_e (P_IDLE/P_BUSY/P_WAIT).
  - Register offset constants OFF_OCC/OFF_MAX/OFF_WBLK/OFF_RBLK and OFF_BUSY/OFF_STALL/OFF_ITER/OFF_STAT.
  - A saturating-increment function.
- Sub-module df_chan_counter holds one channel's occupancy, peak, block counters and err flag, generated NUM_CHAN times.
- Process trackers, deadlock logic and the read mux stay in the top.

Test Plan:
- Reset, start, then 5 writes with no reads on chan0 → occupancy=5, max_occ=5; then 2 reads → occupancy=3, max_occ=5.
- Simultaneous wr_en&rd_en on chan1 for 10 cycles starting at occupancy 2 → occupancy stays 2, no occ_err. A read at occupancy 0 → occupancy 0, occ_err[2]=1.
- proc0: start, 20 busy cycles with in_stall high for 6, then done&continue → busy_cnt=20, stall_cnt=6, iter_cnt=1, state P_IDLE. done with continue=0 for 3 cycles → stays P_WAIT, iter_cnt unchanged until continue.
- DL_THRESH=16, two processes busy with both stalled from cycle 0 → deadlock=1 after exactly 16 cycles, running=0 the next cycle, counters frozen. Unstalling one process at cycle 15 → no deadlock.
- Force wr_block_cnt to all-ones, keep chan_wr_block high → the counter stays all-ones.
- Read addr 4*NUM_CHAN+2 → rd_valid and iter_cnt one cycle later. Out-of-range address → rd_data=0. Assert reset mid-RUN → all outputs 0 immediately.
